// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 raster timing, coordinate/colour widths and palette.
package vga_pkg;

  localparam int unsigned WIDTH   = 640;
  localparam int unsigned HEIGHT  = 480;
  localparam int unsigned H_FRONT = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BACK  = 48;
  localparam int unsigned H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_FRONT = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BACK  = 33;
  localparam int unsigned V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned COLOR_W = 3;
  localparam int unsigned COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

  localparam rgb_t C_BLACK  = '{r: 3'b000, g: 3'b000, b: 3'b000};
  localparam rgb_t C_DIM    = '{r: 3'b010, g: 3'b010, b: 3'b010};
  localparam rgb_t C_YELLOW = '{r: 3'b111, g: 3'b111, b: 3'b000};

  typedef enum logic {
    DirPos = 1'b0,
    DirNeg = 1'b1
  } dir_t;

  // Half-open span test: lo <= v < lo + len, all in coordinate width.
  function automatic logic in_span(coord_t v, coord_t lo, coord_t len);
    return (v >= lo) && (v < coord_t'(lo + len));
  endfunction

endpackage

// File: rtl/vga_axis_bounce.sv
// One axis of the bouncing box: position walks by SPEED per step and reflects at 0 and LIMIT.
module vga_axis_bounce
  import vga_pkg::*;
#(
  parameter int unsigned LIMIT = 608,
  parameter int unsigned SPEED = 2
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_step,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_dir
);

  localparam coord_t LimitC = COORD_W'(LIMIT);
  localparam coord_t SpeedC = COORD_W'(SPEED);

  coord_t pos;
  dir_t   dir;

  // Edge hits clamp exactly onto the boundary so pos never leaves [0, LIMIT].
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pos <= '0;
      dir <= DirPos;
    end else if (i_step) begin
      unique case (dir)
        DirPos: begin
          if (coord_t'(pos + SpeedC) >= LimitC) begin
            pos <= LimitC;
            dir <= DirNeg;
          end else begin
            pos <= pos + SpeedC;
          end
        end
        DirNeg: begin
          if (pos <= SpeedC) begin
            pos <= '0;
            dir <= DirPos;
          end else begin
            pos <= pos - SpeedC;
          end
        end
      endcase
    end
  end

  assign o_pos = pos;
  assign o_dir = (dir == DirNeg);

endmodule

// File: rtl/vga_bounce_box.sv
// Pixel-colour stage: bouncing yellow box over a dim checkerboard, syncs re-aligned to RGB.
module vga_bounce_box #(
  parameter int unsigned WIDTH  = vga_pkg::WIDTH,
  parameter int unsigned HEIGHT = vga_pkg::HEIGHT,
  parameter int unsigned BOX    = 32,
  parameter int unsigned SPEED  = 2,
  parameter int unsigned CHK    = 5
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_HSync,
  input  logic        i_VSync,
  input  logic        i_valid,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic        i_Enable,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic [2:0]  o_R,
  output logic [2:0]  o_G,
  output logic [2:0]  o_B
);

  import vga_pkg::*;

  localparam coord_t BoxC = COORD_W'(BOX);

  coord_t     x1, y1;
  logic       vsync_prev;
  logic       tick, step;
  coord_t     bx, by;
  logic [1:0] dir_unused;  // directions are internal to each axis
  rgb_t       pix_d, pix_q;
  logic       hsync_q, vsync_q;

  // Frame tick on the VSync falling edge; positions only move during vertical blanking.
  assign tick = vsync_prev & ~i_VSync;
  assign step = tick & i_Enable;

  vga_axis_bounce #(
    .LIMIT(WIDTH - BOX),
    .SPEED(SPEED)
  ) u_axis_x (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_step (step),
    .o_pos  (bx),
    .o_dir  (dir_unused[0])
  );

  vga_axis_bounce #(
    .LIMIT(HEIGHT - BOX),
    .SPEED(SPEED)
  ) u_axis_y (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_step (step),
    .o_pos  (by),
    .o_dir  (dir_unused[1])
  );

  always_comb begin
    pix_d = C_BLACK;
    if (!i_valid) begin
      pix_d = C_BLACK;
    end else if (in_span(x1, bx, BoxC) && in_span(y1, by, BoxC)) begin
      pix_d = C_YELLOW;
    end else if (x1[CHK] ^ y1[CHK]) begin
      pix_d = C_DIM;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      x1         <= '0;
      y1         <= '0;
      vsync_prev <= 1'b1;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      pix_q      <= C_BLACK;
    end else begin
      x1         <= i_x;
      y1         <= i_y;
      vsync_prev <= i_VSync;
      hsync_q    <= i_HSync;
      vsync_q    <= i_VSync;
      pix_q      <= pix_d;
    end
  end

  assign o_HSync = hsync_q;
  assign o_VSync = vsync_q;
  assign o_R     = pix_q.r;
  assign o_G     = pix_q.g;
  assign o_B     = pix_q.b;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: reset, colour rule, latency, bounce and corner behaviour.
module tb_vga_bounce_box;

  logic        i_Clk = 1'b0;
  logic        i_Reset, i_HSync, i_VSync, i_valid, i_Enable;
  logic [11:0] i_x, i_y;
  logic        o_HSync, o_VSync;
  logic [2:0]  o_R, o_G, o_B;
  logic        sq_hs, sq_vs;
  logic [2:0]  sq_r, sq_g, sq_b;
  logic [8:0]  rgb;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] YEL = 9'b111_111_000;
  localparam logic [8:0] DIM = 9'b010_010_010;
  localparam logic [8:0] BLK = 9'b000_000_000;

  always #5 i_Clk = ~i_Clk;

  vga_bounce_box dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_HSync (i_HSync),
    .i_VSync (i_VSync),
    .i_valid (i_valid),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_Enable(i_Enable),
    .o_HSync (o_HSync),
    .o_VSync (o_VSync),
    .o_R     (o_R),
    .o_G     (o_G),
    .o_B     (o_B)
  );

  // Square screen so both axes reach their far edge on the same tick.
  vga_bounce_box #(
    .WIDTH (480),
    .HEIGHT(480)
  ) dut_sq (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_HSync (i_HSync),
    .i_VSync (i_VSync),
    .i_valid (i_valid),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_Enable(i_Enable),
    .o_HSync (sq_hs),
    .o_VSync (sq_vs),
    .o_R     (sq_r),
    .o_G     (sq_g),
    .o_B     (sq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      i_VSync = 1'b0;
      cyc();
      i_VSync = 1'b1;
      cyc();
    end
  endtask

  task automatic pixel(input int x, input int y, input logic v, output logic [8:0] c);
    i_x     = 12'(x);
    i_y     = 12'(y);
    i_valid = 1'b0;
    cyc();
    i_valid = v;
    i_x     = 12'(x + 1);
    cyc();
    i_valid = 1'b0;
    @(negedge i_Clk);
    c = {o_R, o_G, o_B};
  endtask

  task automatic chk_px(input string tag, input int x, input int y, input logic [8:0] exp);
    logic [8:0] c;
    pixel(x, y, 1'b1, c);
    check(tag, c, exp);
  endtask

  task automatic chk_pos(input string tag, input int ex, input int edx, input int ey,
                         input int edy);
    check({tag, "_bx"}, dut.u_axis_x.o_pos, ex);
    check({tag, "_dx"}, dut.u_axis_x.o_dir, edx);
    check({tag, "_by"}, dut.u_axis_y.o_pos, ey);
    check({tag, "_dy"}, dut.u_axis_y.o_dir, edy);
  endtask

  initial begin
    i_Reset  = 1'b1;
    i_HSync  = 1'b1;
    i_VSync  = 1'b1;
    i_valid  = 1'b0;
    i_x      = '0;
    i_y      = '0;
    i_Enable = 1'b0;
    cyc();

    // Reset held mid-line with live-looking inputs: outputs must stay idle.
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      i_x     = 12'(5 + i);
      i_y     = 12'd3;
      i_HSync = i[0];
      i_VSync = (i >= 2 && i <= 5) ? 1'b0 : 1'b1;
      cyc();
      check("rst_rgb", {o_R, o_G, o_B}, BLK);
      check("rst_hs", o_HSync, 1);
      check("rst_vs", o_VSync, 1);
    end
    i_Reset = 1'b0;
    i_HSync = 1'b1;
    i_VSync = 1'b1;
    i_valid = 1'b0;
    chk_pos("rst", 0, 0, 0, 0);
    chk_px("px_origin", 0, 0, YEL);

    // Latency: coordinate to RGB is two edges.
    i_x = 12'd20;
    i_y = 12'd20;
    i_valid = 1'b0;
    cyc();
    check("lat_1cyc", o_R, 0);
    i_valid = 1'b1;
    i_x = 12'd21;
    cyc();
    check("lat_2cyc", o_R, 7);
    i_valid = 1'b0;
    cyc();
    check("lat_after", o_R, 0);
    pixel(10, 10, 1'b0, rgb);
    check("px_invalid", rgb, BLK);

    // Syncs: one edge of delay.
    i_HSync = 1'b0;
    check("hs_before", o_HSync, 1);
    cyc();
    check("hs_fall", o_HSync, 0);
    cyc();
    check("hs_low", o_HSync, 0);
    i_HSync = 1'b1;
    cyc();
    check("hs_rise", o_HSync, 1);
    i_VSync = 1'b0;
    cyc();
    check("vs_fall", o_VSync, 0);
    i_VSync = 1'b1;
    cyc();
    check("vs_rise", o_VSync, 1);
    chk_pos("frozen0", 0, 0, 0, 0);

    // Motion: three ticks move the box to (6,6).
    i_Enable = 1'b1;
    frames(3);
    chk_pos("f3", 6, 0, 6, 0);
    chk_px("px_6_6", 6, 6, YEL);
    chk_px("px_37_37", 37, 37, YEL);
    chk_px("px_38_38", 38, 38, BLK);
    chk_px("px_5_5", 5, 5, BLK);
    chk_px("px_32_0", 32, 0, DIM);
    chk_px("px_100_6", 100, 6, DIM);

    frames(218);
    chk_pos("f221", 442, 0, 442, 0);
    frames(3);
    chk_pos("f224", 448, 0, 448, 1);
    check("sq224_bx", dut_sq.u_axis_x.o_pos, 448);
    check("sq224_dx", dut_sq.u_axis_x.o_dir, 1);
    check("sq224_by", dut_sq.u_axis_y.o_pos, 448);
    check("sq224_dy", dut_sq.u_axis_y.o_dir, 1);
    chk_px("px_479_479", 479, 479, YEL);
    chk_px("px_480_479", 480, 479, DIM);

    frames(1);
    chk_pos("f225", 450, 0, 446, 1);
    check("sq225_bx", dut_sq.u_axis_x.o_pos, 446);
    check("sq225_by", dut_sq.u_axis_y.o_pos, 446);

    frames(78);
    chk_pos("f303", 606, 0, 290, 1);
    frames(1);
    chk_pos("f304", 608, 1, 288, 1);
    frames(1);
    chk_pos("f305", 606, 1, 286, 1);
    frames(143);
    chk_pos("f448", 320, 1, 0, 0);

    // Frozen while disabled.
    i_Enable = 1'b0;
    frames(4);
    chk_pos("hold", 320, 1, 0, 0);

    // Reset asserted on the VSync falling edge: the tick is dropped.
    i_Enable = 1'b1;
    i_VSync  = 1'b0;
    i_Reset  = 1'b1;
    cyc();
    check("rstv_vs", o_VSync, 1);
    cyc();
    i_VSync = 1'b1;
    cyc();
    i_Reset = 1'b0;
    chk_pos("rstv", 0, 0, 0, 0);
    cyc();
    chk_pos("rstv_post", 0, 0, 0, 0);
    frames(1);
    chk_pos("rstv_tick", 2, 0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
